lcd_display_cpu_mult_seq: RTL and testbench
===========================================

// Module: lcd_display_cpu_mult_seq
// PURPOSE
//  Parametrised, slice-iterative integer multiplier for the CPU multiply path.
//  Forms the full 2*DATA_W product, accumulating one SLICE_W-wide slice of operand B per cycle.
//  Supports low-word MUL and high-word MULXSS/MULXSU/MULXUU with valid/ready handshakes.
//  Sits between the CPU execute stage and writeback; replaces fixed 2-partial-product cells.
// PARAMETERS
//  DATA_W   32  operand/result width; must be a multiple of SLICE_W
//  SLICE_W  16  B-slice width per iteration; NUM_SLICES = DATA_W/SLICE_W (>=1)
// PORTS
//  clk        in   1       sole clock; all state changes on rising edge
//  reset      in   1       synchronous, active-high reset
//  flush      in   1       synchronous abort: return to IDLE, discard in-flight op
//  in_valid   in   1       operands/mode valid
//  in_ready   out  1       block can accept operands (high only in IDLE)
//  in_mode    in   2       00 MUL lo, 01 MULXSS hi, 10 MULXSU hi (A signed), 11 MULXUU hi
//  in_a       in   DATA_W  operand A
//  in_b       in   DATA_W  operand B
//  out_valid  out  1       result valid; held until accepted
//  out_ready  in   1       consumer accepts result
//  out_result out  DATA_W  product word selected by mode
//  busy       out  1       high in ACC or FIX
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, out_valid=0, busy=0, out_result=0, accumulator=0.
//  reset has priority over flush; flush has priority over all handshakes.
//  FSM states: IDLE, ACC, FIX, DONE.
//   IDLE: in_ready=1. On in_valid:
//    - Register A as Aext: 2*DATA_W, sign-extended if mode 01/10, else zero-extended.
//    - Register B and mode; acc=0; slice index=0; next state ACC.
//   ACC: each edge, acc += (Aext * B[i*SLICE_W +: SLICE_W]) << (i*SLICE_W), taking the slice unsigned.
//    - i increments after each add; after slice NUM_SLICES-1, go to FIX.
//   FIX: if mode==01 and B[DATA_W-1]==1, acc -= Aext << DATA_W; otherwise no change.
//    - The cycle is always spent, so latency is fixed. Load out_result, set out_valid, go to DONE.
//   DONE: out_valid=1 and out_result stable. On out_ready, drop out_valid and go to IDLE.
//    - The next op is accepted no earlier than the following edge; no overlap.
//  Arithmetic: acc is 2*DATA_W bits, modulo 2^(2*DATA_W), with no overflow flag.
//   - mode 00 outputs acc[DATA_W-1:0]; all other modes output acc[2*DATA_W-1:DATA_W].
//  Latency: out_valid rises NUM_SLICES+1 edges after the accepting edge (3 at default).
//   - Throughput: one op per NUM_SLICES+3 cycles with out_ready held high.
//  in_valid while not IDLE is ignored; no operand is captured.
//  out_ready while not DONE is ignored.
//  flush or reset in any state -> IDLE next edge, out_valid=0, no result emitted.
//   - out_result is cleared only by reset; flush leaves it unchanged.
//  NUM_SLICES==1 is legal: ACC lasts 1 cycle.
// TESTING
//  1 MUL: A=0x0000FFFF, B=0x0000FFFF -> out_result=0xFFFE0001, out_valid 3 edges after accept.
//  2 MULXSS: A=B=0xFFFFFFFF (-1*-1) -> 0x00000000; MUL mode same operands -> 0x00000001.
//  3 MULXUU A=B=0xFFFFFFFF -> 0xFFFFFFFE; MULXSU same operands -> 0xFFFFFFFF.
//  4 Backpressure: out_ready low 5 cycles in DONE -> out_valid/out_result held, in_ready=0, extra in_valid ignored.
//  5 reset or flush asserted in ACC -> next edge IDLE, in_ready=1, out_valid never pulses; next op correct.
//  6 SLICE_W=8: A=0x12345678, B=0x9ABCDEF0 MULXUU -> 0x0B00EA4E, out_valid 5 edges after accept.

Source files
------------

// File: rtl/lcd_display_cpu_mult_seq.sv
// Slice-iterative 2*DATA_W multiplier, one SLICE_W chunk of B per cycle.
// Ports: clk, reset, flush, in_valid/in_ready/in_mode/in_a/in_b, out_valid/out_ready/out_result, busy.
module lcd_display_cpu_mult_seq #(
  parameter int DATA_W  = 32,
  parameter int SLICE_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_mode,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              busy
);

  localparam int NS = DATA_W / SLICE_W;
  localparam int P  = 2 * DATA_W;
  localparam int IW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NS - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIX,
    DONE
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] a_reg;
  logic [P-1:0]      a_sh;
  logic [DATA_W-1:0] b_sh;
  logic              b_msb;
  logic [1:0]        mode_r;
  logic [IW-1:0]     idx;
  logic [P-1:0]      acc;

  logic [P-1:0] slice_prod;
  logic [P-1:0] fixed;
  logic         sext;

  // a_sh already carries the i*SLICE_W weight; slice taken unsigned
  assign slice_prod = a_sh * P'(b_sh[SLICE_W-1:0]);

  // signed*signed: B's MSB was weighted +2^(W-1) instead of -2^(W-1)
  assign fixed = (mode_r == 2'b01 && b_msb)
               ? acc - {a_reg, {DATA_W{1'b0}}}
               : acc;

  assign sext     = in_mode[0] ^ in_mode[1];
  assign in_ready = (state == IDLE);
  assign busy     = (state == ACC) || (state == FIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      acc        <= '0;
      a_reg      <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      b_msb      <= 1'b0;
      mode_r     <= '0;
      idx        <= '0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg  <= in_a;
            a_sh   <= sext ? {{DATA_W{in_a[DATA_W-1]}}, in_a}
                           : {{DATA_W{1'b0}}, in_a};
            b_sh   <= in_b;
            b_msb  <= in_b[DATA_W-1];
            mode_r <= in_mode;
            acc    <= '0;
            idx    <= '0;
            state  <= ACC;
          end
        end
        ACC: begin
          acc  <= acc + slice_prod;
          a_sh <= a_sh << SLICE_W;
          b_sh <= b_sh >> SLICE_W;
          idx  <= idx + 1'b1;
          if (idx == LAST) state <= FIX;
        end
        FIX: begin
          acc        <= fixed;
          out_result <= (mode_r == 2'b00) ? fixed[DATA_W-1:0]
                                          : fixed[P-1:DATA_W];
          out_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_display_cpu_mult_seq.sv
// Bench for lcd_display_cpu_mult_seq: vector table, corner sequences, random ops.
// Drives on negedge, samples 1 time unit after posedge.
module tb_lcd_display_cpu_mult_seq;

  logic        clk = 0;
  logic        reset, flush;
  logic        in_valid, in_valid8;
  logic        in_ready, in_ready8;
  logic [1:0]  in_mode;
  logic [31:0] in_a, in_b;
  logic        out_valid, out_valid8;
  logic        out_ready, out_ready8;
  logic [31:0] out_result, out_result8;
  logic        busy, busy8;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  lcd_display_cpu_mult_seq #(.DATA_W(32), .SLICE_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .busy(busy)
  );

  lcd_display_cpu_mult_seq #(.DATA_W(32), .SLICE_W(8)) dut8 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .in_mode(in_mode), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_result(out_result8), .busy(busy8)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  function automatic logic [31:0] model(logic [1:0] m,
                                        logic [31:0] a,
                                        logic [31:0] b);
    logic [63:0] xa, xb, full;
    xa = (m == 2'b01 || m == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
    xb = (m == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
    full = xa * xb;
    return (m == 2'b00) ? full[31:0] : full[63:32];
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Runs one op on either instance; checks latency and result, then accepts.
  task automatic run_op(bit sel8, logic [1:0] m, logic [31:0] a,
                        logic [31:0] b, logic [31:0] exp, int lat,
                        string name);
    int n;
    bit got;
    @(negedge clk);
    n = 0;
    while (!(sel8 ? in_ready8 : in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, " in_ready"}, 32'(sel8 ? in_ready8 : in_ready), 32'd1);
    in_mode = m;
    in_a    = a;
    in_b    = b;
    if (sel8) in_valid8 = 1; else in_valid = 1;
    @(posedge clk);
    #1;
    in_valid  = 0;
    in_valid8 = 0;
    n   = 0;
    got = 0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      got = sel8 ? out_valid8 : out_valid;
    end
    chk({name, " latency"}, 32'(n), 32'(lat));
    chk({name, " result"}, sel8 ? out_result8 : out_result, exp);
    @(negedge clk);
    if (sel8) out_ready8 = 1; else out_ready = 1;
    @(posedge clk);
    #1;
    out_ready  = 0;
    out_ready8 = 0;
    chk({name, " valid drop"}, 32'(sel8 ? out_valid8 : out_valid), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1;
    @(posedge clk);
    #1;
    @(negedge clk);
    reset = 0;
  endtask

  vec_t tbl[8];

  initial begin
    logic [31:0] held;
    logic [1:0]  m;
    logic [31:0] ra, rb;

    tbl[0] = '{2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001};
    tbl[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};
    tbl[2] = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001};
    tbl[3] = '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE};
    tbl[4] = '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    tbl[5] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000};
    tbl[6] = '{2'b10, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF};
    tbl[7] = '{2'b01, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFF};

    reset = 1; flush = 0;
    in_valid = 0; in_valid8 = 0;
    out_ready = 0; out_ready8 = 0;
    in_mode = 0; in_a = 0; in_b = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst out_result", out_result, 32'd0);
    @(negedge clk);
    reset = 0;

    foreach (tbl[i])
      run_op(0, tbl[i].mode, tbl[i].a, tbl[i].b, tbl[i].exp, 3,
             $sformatf("vec%0d", i));

    // backpressure: hold in DONE, inject ignored in_valid
    run_op(0, 2'b11, 32'd7, 32'd9, 32'd0, 3, "pre bp");
    @(negedge clk);
    in_mode = 2'b00; in_a = 32'h00001234; in_b = 32'h00000010;
    in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("bp first valid", 32'(out_valid), 32'd1);
    held = out_result;
    chk("bp first result", held, 32'h00012340);
    @(negedge clk);
    in_mode = 2'b11; in_a = 32'hDEADBEEF; in_b = 32'hCAFEF00D;
    in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk("bp valid held", 32'(out_valid), 32'd1);
      chk("bp result held", out_result, 32'h00012340);
      chk("bp in_ready low", 32'(in_ready), 32'd0);
    end
    in_valid = 0;
    @(negedge clk);
    out_ready = 1;
    @(posedge clk);
    #1;
    out_ready = 0;
    chk("bp released", 32'(out_valid), 32'd0);
    chk("bp idle", 32'(in_ready), 32'd1);
    run_op(0, 2'b00, 32'd100, 32'd200, 32'd20000, 3, "post bp");

    // flush in ACC: no result, out_result untouched
    @(negedge clk);
    in_mode = 2'b00; in_a = 32'd5; in_b = 32'd6; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    chk("fl busy", 32'(busy), 32'd1);
    @(negedge clk);
    flush = 1;
    @(posedge clk);
    #1;
    flush = 0;
    chk("fl in_ready", 32'(in_ready), 32'd1);
    chk("fl busy low", 32'(busy), 32'd0);
    held = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      held = held | 32'(out_valid);
    end
    chk("fl no pulse", held, 32'd0);
    chk("fl result kept", out_result, 32'd20000);
    run_op(0, 2'b01, 32'hFFFFFFF0, 32'd4, 32'hFFFFFFFF, 3, "post fl");

    // reset in ACC: result cleared
    @(negedge clk);
    in_mode = 2'b11; in_a = 32'd9; in_b = 32'd9; in_valid = 1;
    @(posedge clk);
    #1;
    in_valid = 0;
    do_reset();
    #1;
    chk("rs in_ready", 32'(in_ready), 32'd1);
    chk("rs out_valid", 32'(out_valid), 32'd0);
    chk("rs out_result", out_result, 32'd0);
    run_op(0, 2'b00, 32'h0000FFFF, 32'h0000FFFF, 32'hFFFE0001, 3,
           "post rs");

    // narrow slice instance
    run_op(1, 2'b11, 32'h12345678, 32'h9ABCDEF0, 32'h0B00EA4E, 5,
           "slice8");

    // random ops on both instances against the model
    for (int k = 0; k < 40; k++) begin
      m  = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if (k % 8 == 0) ra = 32'h80000000;
      if (k % 8 == 1) rb = 32'h80000000;
      run_op(k[0], m, ra, rb, model(m, ra, rb), k[0] ? 5 : 3,
             $sformatf("rnd%0d m%0d", k, m));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
